// File: rtl/ecc_apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_apb_pkg
//  Description : Shared definitions for the ECC APB register slave:
//                register addresses, CTRL / CODEWORD_WIDTH encodings and the
//                APB FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package ecc_apb_pkg;

    // Register byte addresses (full-address match)
    localparam logic [31:0] c_ADDR_CTRL     = 32'h0000_0000;
    localparam logic [31:0] c_ADDR_DATA_IN  = 32'h0000_0004;
    localparam logic [31:0] c_ADDR_CW_WIDTH = 32'h0000_0008;
    localparam logic [31:0] c_ADDR_NOISE    = 32'h0000_000C;

    // CTRL register encoding
    typedef enum logic [1:0] {
        CTRL_ENCODE = 2'd0,
        CTRL_DECODE = 2'd1,
        CTRL_FULL   = 2'd2,
        CTRL_RSVD   = 2'd3
    } ctrl_e;

    // CODEWORD_WIDTH register encoding
    typedef enum logic [1:0] {
        CW_8BIT  = 2'd0,
        CW_16BIT = 2'd1,
        CW_32BIT = 2'd2,
        CW_RSVD  = 2'd3
    } cw_width_e;

    // APB slave FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } apb_state_e;

endpackage : ecc_apb_pkg
`default_nettype wire

// File: rtl/ecc_apb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_apb_slave
//  Description : APB register slave for an ECC core. Holds CTRL, DATA_IN,
//                CODEWORD_WIDTH and NOISE, issues a one-cycle start pulse on
//                a valid CTRL write and tracks busy until operation_done.
//                Writes arriving while busy are stalled (pready=0) until the
//                core completes.
//  Ports       : clk, rst (sync, active-high)
//                APB  : paddr, psel, penable, pwrite, pwdata -> prdata,
//                       pready, pslverr
//                Core : ctrl, codeword_width, data_in, noise, start, busy
//                       <- operation_done
//  Config      : define ECC_APB_PSLVERR_EN to flag unmapped accesses and
//                CTRL writes of value 3 on pslverr; otherwise pslverr is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module ecc_apb_slave
    import ecc_apb_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AMBA_ADDR_WIDTH-1:0] paddr,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [AMBA_WORD-1:0]       pwdata,
    output logic [AMBA_WORD-1:0]       prdata,
    output logic                       pready,
    output logic                       pslverr,
    output logic [1:0]                 ctrl,
    output logic [1:0]                 codeword_width,
    output logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      noise,
    output logic                       start,
    input  logic                       operation_done,
    output logic                       busy
);

    apb_state_e            r_state;
    logic [1:0]            r_ctrl;
    logic [1:0]            r_cw;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [DATA_WIDTH-1:0] r_noise;
    logic [AMBA_WORD-1:0]  r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic                  r_start;
    logic                  r_busy;

    logic                  w_sel_ctrl;
    logic                  w_sel_data;
    logic                  w_sel_cw;
    logic                  w_sel_noise;
    logic                  w_mapped;
    logic                  w_setup;
    logic                  w_access;
    logic                  w_commit;
    logic                  w_ctrl_go;
    logic                  w_err;
    logic [AMBA_WORD-1:0]  w_rdata;

    // ------------------------------------------------------------------------
    // Address decode and read mux
    // ------------------------------------------------------------------------
    always_comb begin
        w_sel_ctrl  = (paddr == AMBA_ADDR_WIDTH'(c_ADDR_CTRL));
        w_sel_data  = (paddr == AMBA_ADDR_WIDTH'(c_ADDR_DATA_IN));
        w_sel_cw    = (paddr == AMBA_ADDR_WIDTH'(c_ADDR_CW_WIDTH));
        w_sel_noise = (paddr == AMBA_ADDR_WIDTH'(c_ADDR_NOISE));
        w_mapped    = w_sel_ctrl | w_sel_data | w_sel_cw | w_sel_noise;

        w_rdata = '0;
        if (w_sel_ctrl)  w_rdata = AMBA_WORD'(r_ctrl);
        if (w_sel_data)  w_rdata = AMBA_WORD'(r_data_in);
        if (w_sel_cw)    w_rdata = AMBA_WORD'(r_cw);
        if (w_sel_noise) w_rdata = AMBA_WORD'(r_noise);
    end

    assign w_setup  = psel & ~penable;
    assign w_access = psel & penable;
    // r_pready is only ever high in SETUP or a released WAIT, so this is the
    // single write-commit point regardless of which path got us here.
    assign w_commit = w_access & r_pready & pwrite;
    // Only a CTRL write with a legal operation and a legal width launches.
    assign w_ctrl_go = (pwdata[1:0] != CTRL_RSVD) && (r_cw != CW_RSVD);

`ifdef ECC_APB_PSLVERR_EN
    assign w_err = ~w_mapped | (pwrite & w_sel_ctrl & (pwdata[1:0] == CTRL_RSVD));
`else
    assign w_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Register file, start/busy and APB FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ctrl    <= '0;
            r_cw      <= '0;
            r_data_in <= '0;
            r_noise   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_start <= 1'b0;

            // A launch cannot coincide with a busy operation (writes stall),
            // so launch and completion never conflict in practice.
            if (w_commit && w_sel_ctrl && w_ctrl_go) begin
                r_busy <= 1'b1;
            end else if (operation_done) begin
                r_busy <= 1'b0;
            end

            if (w_commit) begin
                if (w_sel_ctrl) begin
                    r_ctrl  <= pwdata[1:0];
                    r_start <= w_ctrl_go;
                end
                if (w_sel_data)  r_data_in <= pwdata[DATA_WIDTH-1:0];
                if (w_sel_cw)    r_cw      <= pwdata[1:0];
                if (w_sel_noise) r_noise   <= pwdata[DATA_WIDTH-1:0];
            end

            case (r_state)
                ST_IDLE, ST_ACCESS: begin
                    // penable without a setup phase is simply ignored here
                    if (w_setup) begin
                        if (pwrite && r_busy) begin
                            r_state  <= ST_WAIT;
                            r_pready <= 1'b0;
                        end else begin
                            r_state   <= ST_SETUP;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= pwrite ? '0 : w_rdata;
                        end
                    end else if (!psel) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    // Zero-wait access phase: always finishes this cycle
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                    r_state   <= w_access ? ST_ACCESS : ST_IDLE;
                end
                ST_WAIT: begin
                    if (!psel) begin
                        r_state   <= ST_IDLE;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end else if (r_pready) begin
                        r_state   <= w_access ? ST_ACCESS : ST_IDLE;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end else if (!r_busy || operation_done) begin
                        // Core finished: release the stalled write next cycle
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign prdata         = r_prdata;
    assign pready         = r_pready;
    assign pslverr        = r_pslverr;
    assign ctrl           = r_ctrl;
    assign codeword_width = r_cw;
    assign data_in        = r_data_in;
    assign noise          = r_noise;
    assign start          = r_start;
    assign busy           = r_busy;

endmodule : ecc_apb_slave
`default_nettype wire

// File: tb/tb_ecc_apb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ecc_apb_slave
//  Description : Directed self-checking bench for ecc_apb_slave. Expected
//                pslverr values follow ECC_APB_PSLVERR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_apb_slave;

`ifdef ECC_APB_PSLVERR_EN
    localparam logic c_ERR_EN = 1'b1;
`else
    localparam logic c_ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [19:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  ctrl;
    logic [1:0]  codeword_width;
    logic [31:0] data_in;
    logic [31:0] noise;
    logic        start;
    logic        operation_done;
    logic        busy;

    int          checks;
    int          errors;
    int          wait_n;
    logic [31:0] rd_val;
    logic        err_val;
    logic [31:0] pre_data;

    ecc_apb_slave #(
        .AMBA_WORD       (32),
        .AMBA_ADDR_WIDTH (20),
        .DATA_WIDTH      (32)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .paddr          (paddr),
        .psel           (psel),
        .penable        (penable),
        .pwrite         (pwrite),
        .pwdata         (pwdata),
        .prdata         (prdata),
        .pready         (pready),
        .pslverr        (pslverr),
        .ctrl           (ctrl),
        .codeword_width (codeword_width),
        .data_in        (data_in),
        .noise          (noise),
        .start          (start),
        .operation_done (operation_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // done_at: access-phase cycle index in which operation_done is pulsed (-1: never)
    task automatic apb_write(input logic [19:0] a, input logic [31:0] d, input int done_at);
        int n;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1; n = 0; operation_done = (done_at == 0);
        while (!pready && n < 40) begin
            @(posedge clk); #1;
            n++;
            operation_done = (n == done_at);
        end
        if (!pready) check_val("wr_pready_timeout", 32'(pready), 32'd1);
        wait_n   = n;
        err_val  = pslverr;
        pre_data = data_in;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; operation_done = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] a);
        int n;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1; n = 0;
        while (!pready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!pready) check_val("rd_pready_timeout", 32'(pready), 32'd1);
        wait_n  = n;
        rd_val  = prdata;
        err_val = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_prdata"}, prdata, 32'h0);
        check_val({tag, "_pready"}, 32'(pready), 32'h0);
        check_val({tag, "_pslverr"}, 32'(pslverr), 32'h0);
        check_val({tag, "_start"}, 32'(start), 32'h0);
        check_val({tag, "_busy"}, 32'(busy), 32'h0);
        check_val({tag, "_ctrl"}, 32'(ctrl), 32'h0);
        check_val({tag, "_cw"}, 32'(codeword_width), 32'h0);
        check_val({tag, "_data_in"}, data_in, 32'h0);
        check_val({tag, "_noise"}, noise, 32'h0);
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; operation_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // ---- Basic register writes and launch ----
        apb_write(20'h4, 32'h02AB_CDEF, -1);
        check_val("wr_err_mapped", 32'(err_val), 32'h0);
        check_val("wr_zero_wait", 32'(wait_n), 32'd0);
        apb_write(20'h8, 32'h2, -1);
        apb_write(20'hC, 32'h11, -1);
        apb_write(20'h0, 32'h2, -1);
        check_val("data_in", data_in, 32'h02AB_CDEF);
        check_val("cw", 32'(codeword_width), 32'h2);
        check_val("noise", noise, 32'h11);
        check_val("ctrl", 32'(ctrl), 32'h2);
        check_val("start_pulse", 32'(start), 32'h1);
        check_val("busy_set", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check_val("start_one_cycle", 32'(start), 32'h0);
        check_val("busy_held", 32'(busy), 32'h1);
        operation_done = 1'b1;
        @(posedge clk); #1;
        operation_done = 1'b0;
        check_val("busy_clear", 32'(busy), 32'h0);
        operation_done = 1'b1;
        @(posedge clk); #1;
        operation_done = 1'b0;
        check_val("done_idle_busy", 32'(busy), 32'h0);
        check_val("done_idle_start", 32'(start), 32'h0);

        // ---- Write stalled by busy ----
        apb_write(20'h0, 32'h0, -1);
        check_val("start_pulse2", 32'(start), 32'h1);
        apb_write(20'h4, 32'h1234_5678, 4);
        check_val("stall_cycles", 32'(wait_n), 32'd5);
        check_val("stall_no_early", pre_data, 32'h02AB_CDEF);
        check_val("stall_busy", 32'(busy), 32'h0);
        check_val("stall_commit", data_in, 32'h1234_5678);

        // ---- Readback ----
        apb_write(20'h8, 32'h1, -1);
        apb_read(20'h8);
        check_val("rd_cw", rd_val, 32'h1);
        check_val("rd_zero_wait", 32'(wait_n), 32'd0);
        check_val("rd_err", 32'(err_val), 32'h0);
        check_val("prdata_idle", prdata, 32'h0);
        apb_read(20'h4);
        check_val("rd_data_in", rd_val, 32'h1234_5678);

        // ---- Unmapped address ----
        apb_read(20'h10);
        check_val("rd_unmapped", rd_val, 32'h0);
        check_val("rd_unmapped_err", 32'(err_val), 32'(c_ERR_EN));
        apb_write(20'h10, 32'hFFFF_FFFF, -1);
        check_val("wr_unmapped_err", 32'(err_val), 32'(c_ERR_EN));
        check_val("wr_unmapped_data", data_in, 32'h1234_5678);
        check_val("wr_unmapped_noise", noise, 32'h11);
        check_val("wr_unmapped_ctrl", 32'(ctrl), 32'h0);
        check_val("wr_unmapped_cw", 32'(codeword_width), 32'h1);

        // ---- Reserved encodings ----
        apb_write(20'h0, 32'h3, -1);
        check_val("ctrl3_err", 32'(err_val), 32'(c_ERR_EN));
        check_val("ctrl3_val", 32'(ctrl), 32'h3);
        check_val("ctrl3_start", 32'(start), 32'h0);
        check_val("ctrl3_busy", 32'(busy), 32'h0);
        apb_write(20'h8, 32'h3, -1);
        apb_write(20'h0, 32'h1, -1);
        check_val("cw3_ctrl", 32'(ctrl), 32'h1);
        check_val("cw3_start", 32'(start), 32'h0);
        check_val("cw3_busy", 32'(busy), 32'h0);
        apb_read(20'h0);
        check_val("rd_ctrl", rd_val, 32'h1);

        // ---- Reset during busy with a stalled write ----
        apb_write(20'h8, 32'h2, -1);
        apb_write(20'h0, 32'h0, -1);
        check_val("pre_rst_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h4; pwdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check_val("stalled_pready", 32'(pready), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("mid_rst");
        rst = 1'b0;
        operation_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            operation_done = 1'b0;
            check_val("post_rst_pready", 32'(pready), 32'h0);
            check_val("post_rst_data", data_in, 32'h0);
            check_val("post_rst_start", 32'(start), 32'h0);
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        check_val("post_rst_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ecc_apb_slave
`default_nettype wire
